// File: rtl/dec_stream_nxm_pkg.sv
// Shared types and constants for the streaming N-to-2^N one-hot decoder.
package dec_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic MODE_SINGLE = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/dec_stream_nxm_onehot_dec.sv
// Combinational binary-to-one-hot decoder; a cleared enable forces all outputs inactive.
module onehot_dec #(
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0]      i_code,
  input  logic                  i_en,
  output logic [(1<<SEL_W)-1:0] o_y
);

  localparam int OUT_W = 1 << SEL_W;

  assign o_y = i_en ? (OUT_W'(1) << i_code) : '0;

endmodule

// File: rtl/dec_stream_nxm.sv
// Registered one-hot decoder with valid/ready handshake and a wrap-around scan mode.
// Build option: define DEC_ACTIVE_LOW_EN for an inverted (active-low) y output.
module dec_stream_nxm
  import dec_pkg::*;
#(
  parameter int SEL_W = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      scan_len,
  input  logic                  en,
  output logic [(1<<SEL_W)-1:0] y,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  scan_done
);

  localparam int OUT_W = 1 << SEL_W;
`ifdef DEC_ACTIVE_LOW_EN
  localparam logic [OUT_W-1:0] Y_IDLE = {OUT_W{1'b1}};
`else
  localparam logic [OUT_W-1:0] Y_IDLE = {OUT_W{1'b0}};
`endif

  state_t             r_state;
  state_t             w_next_state;
  logic [SEL_W-1:0]   r_code;
  logic [SEL_W-1:0]   r_rem;
  logic               r_en;
  logic [OUT_W-1:0]   r_y;
  logic               r_out_valid;
  logic               r_rdy;
  logic               w_in_ready;
  logic               w_busy;
  logic               w_scan_done;
  logic               w_in_hs;
  logic               w_out_hs;
  logic               w_last;
  logic               w_advance;
  logic [SEL_W-1:0]   w_dec_code;
  logic               w_dec_en;
  logic [OUT_W-1:0]   w_dec_y;

  assign w_in_hs    = in_valid && w_in_ready;
  assign w_out_hs   = r_out_valid && out_ready;
  assign w_last     = (r_rem == '0);
  assign w_advance  = (r_state == SCAN) && w_out_hs && !w_last;
  // A fresh request takes priority over the scan increment for the decoder input.
  assign w_dec_code = w_in_hs ? sel : r_code + SEL_W'(1);
  assign w_dec_en   = w_in_hs ? en  : r_en;

  onehot_dec #(.SEL_W(SEL_W)) u_dec (
    .i_code (w_dec_code),
    .i_en   (w_dec_en),
    .o_y    (w_dec_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_rdy   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_rdy   <= 1'b1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (w_in_hs && mode == MODE_SCAN) w_next_state = SCAN;
      SCAN: if (w_out_hs && w_last)
              w_next_state = (w_in_hs && mode == MODE_SCAN) ? SCAN : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // On the final scan beat the slot frees up as it drains, so a new request can ride along.
  always_comb begin
    w_in_ready  = 1'b0;
    w_busy      = 1'b0;
    w_scan_done = 1'b0;
    case (r_state)
      IDLE: w_in_ready = r_rdy && (!r_out_valid || out_ready);
      SCAN: begin
        w_busy      = 1'b1;
        w_in_ready  = r_rdy && w_last && out_ready;
        w_scan_done = w_out_hs && w_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y         <= Y_IDLE;
      r_out_valid <= 1'b0;
      r_code      <= '0;
      r_rem       <= '0;
      r_en        <= 1'b0;
    end else if (w_in_hs) begin
      r_y         <= w_dec_y ^ Y_IDLE;
      r_out_valid <= 1'b1;
      r_code      <= sel;
      r_rem       <= scan_len;
      r_en        <= en;
    end else if (w_advance) begin
      r_y    <= w_dec_y ^ Y_IDLE;
      r_code <= w_dec_code;
      r_rem  <= r_rem - SEL_W'(1);
    end else if (w_out_hs) begin
      r_y         <= Y_IDLE;
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign y         = r_y;
  assign out_valid = r_out_valid;
  assign busy      = w_busy;
  assign scan_done = w_scan_done;

endmodule

// File: doc/dec_stream_nxm.md
Name: dec_stream_nxm

Overview:
Parametrised registered binary-to-one-hot decoder, the generalised successor to the fixed 3x8 decoder. It takes SEL_W-bit select words over a valid/ready handshake and drives a registered 2^SEL_W-bit one-hot word. A scan mode walks the active output across consecutive codes with wrap-around, for row/bank strobing. It sits between a command source and downstream strobe consumers.

Parameters:
SEL_W, 3, select width; output width OUT_W = 2**SEL_W (derived localparam, not overridable)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  request accepted when in_valid && in_ready
sel  input  SEL_W  select code, start code in scan mode
mode  input  1  0 = single decode, 1 = scan
scan_len  input  SEL_W  scan mode only: number of extra beats (total beats = scan_len+1)
en  input  1  decoder enable, sampled with request; 0 -> all outputs inactive
y  output  OUT_W  registered one-hot output
out_valid  output  1  y valid
out_ready  input  1  downstream accepts y when out_valid && out_ready
busy  output  1  high while in SCAN state
scan_done  output  1  one-cycle pulse on handshake of final scan beat

Behaviour:
- Reset (async, rst_n=0): y=0, out_valid=0, busy=0, scan_done=0, state=IDLE. in_ready is driven low while rst_n=0 and returns high on the first clk after release.
- Clock and reset: one clock (clk); reset rst_n is asynchronous and active-low.
- States: IDLE, SCAN.
- IDLE: in_ready = !out_valid || out_ready. This gives a one-entry pipeline register with full throughput.
- Accept in IDLE, mode=0: next edge y <= en ? (1 << sel) : 0 and out_valid <= 1. Latency is 1 clk. State remains IDLE.
- Accept in IDLE, mode=1: capture sel into code register, scan_len into remaining counter, and en. The first beat (code=sel) is loaded into y with out_valid=1. busy=1, state -> SCAN.
- SCAN:
  - in_ready=0.
  - On each out handshake with remaining != 0: code <= code+1 mod OUT_W (7 -> 0 wraps for SEL_W=3), remaining <= remaining-1, and y is loaded with the new code.
  - On the handshake with remaining == 0: scan_done=1 for that cycle, out_valid <= 0 unless a new request is accepted the same cycle, busy <= 0, state -> IDLE.
- Scan exit: in_ready = out_ready on the final beat (remaining==0), so a new request can be accepted in the same cycle as the final handshake.
- scan_len=0: one beat. busy and scan_done still assert.
- Enable in scan: en=0 yields y=0 on every beat, with beat count and handshake unchanged.
- Backpressure: while out_valid && !out_ready, y, code and remaining hold stable. No beat is dropped or duplicated.
- One-hot rule: y has at most one bit set, and is nonzero only when out_valid=1 and the captured en=1. When out_valid=0, y=0.
- Inputs sel, mode, scan_len and en are sampled only on the input handshake.
- Mid-operation reset: rst_n low at any time aborts the scan immediately and applies the reset values.

Optional Feature:
DEC_ACTIVE_LOW_EN
- Defined: y is inverted at the output register (idle/inactive = all ones, selected bit = 0). The reset value of y is all ones.
- Undefined: active-high as above.
- Handshake and timing are identical in both cases.

Decomposition:
- Package dec_pkg: state typedef enum {IDLE, SCAN}; MODE_SINGLE=1'b0, MODE_SCAN=1'b1 constants.
- Sub-module onehot_dec (combinational, parameter SEL_W): code + en -> OUT_W one-hot. It is instantiated once, feeding the y register.
- The FSM, counters and handshake live in the top module.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> y=0, out_valid=0, busy=0 immediately; after release in_ready=1.
- Single decode, SEL_W=3, sel=5, en=1, out_ready=1 -> one clk later y=8'b0010_0000, out_valid=1 for one cycle; sel=5, en=0 -> y=8'h00, out_valid=1.
- Back-to-back sel=0..7 every cycle, out_ready=1 -> y walks 8'h01..8'h80 on consecutive cycles, in_ready constantly 1.
- Scan: sel=6, scan_len=3, en=1 -> y=8'h40, 8'h80, 8'h01, 8'h02 on consecutive cycles. scan_done pulses with 8'h02, busy high for 4 cycles, in_ready=0 for the first 3.
- Backpressure: same scan with out_ready low for 3 cycles at the 8'h80 beat -> y holds 8'h80. The sequence continues 8'h01, 8'h02 with no skip.
- Reset mid-scan at beat 2, then a new single decode of sel=3 -> clean restart, y=8'h08, no residual scan beats.
